wave_period_calculator: RTL and testbench

- Converts the 12 note keys of one keyboard octave into a half-period count for the downstream square/tone generator.
- The tone generator toggles its output every halfPeriodTotal ticks of its 200 kHz sample tick.
- Sits between the key input pins (asynchronous, from switches) and the tone generator.
- A value of 0 means no note, and the generator stays silent.

---
 rtl/wave_period_calculator.sv | 72 +++++++
 tb/tb_wave_period_calculator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/wave_period_calculator.sv
// Maps the 12 keys of one octave to a registered half-period count for the tone generator.
// Keys are asynchronous switch levels, so each one passes through its own 2-flop synchronizer.
module wave_period_calculator #(
    parameter int unsigned OCTAVE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key1,
    input  logic       key2,
    input  logic       key3,
    input  logic       key4,
    input  logic       key5,
    input  logic       key6,
    input  logic       key7,
    input  logic       key8,
    input  logic       key9,
    input  logic       key10,
    input  logic       key11,
    input  logic       key12,
    output logic [9:0] halfPeriodTotal
);

    // Half-period in 200 kHz ticks, round(100000 / f), for C4..B4.
    localparam logic [9:0] BASE_TABLE [12] = '{
        10'd382, 10'd361, 10'd341, 10'd321, 10'd303, 10'd286,
        10'd270, 10'd255, 10'd241, 10'd227, 10'd215, 10'd202
    };

    logic [11:0] key_async;
    logic [11:0] key_meta;
    logic [11:0] key_sync;
    logic [9:0]  base_period;
    logic [9:0]  period_next;

    assign key_async = {key12, key11, key10, key9, key8, key7,
                        key6, key5, key4, key3, key2, key1};

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key_async;
            key_sync <= key_sync_next(key_meta);
        end
    end

    function automatic logic [11:0] key_sync_next(input logic [11:0] meta);
        return meta;
    endfunction

    // Ascending scan: a later (higher-pitch) key overrides any lower one.
    always_comb begin
        base_period = '0;
        for (int i = 0; i < 12; i++) begin
            if (key_sync[i]) begin
                base_period = BASE_TABLE[i];
            end
        end
    end

    assign period_next = base_period >> OCTAVE;

    always_ff @(posedge clk) begin
        if (rst) begin
            halfPeriodTotal <= '0;
        end else begin
            halfPeriodTotal <= period_next;
        end
    end

endmodule

// File: tb/tb_wave_period_calculator.sv
// Directed bench for wave_period_calculator: one default-octave instance and one at OCTAVE=2.
`timescale 1ns/1ps
module tb_wave_period_calculator;

    logic        clk;
    logic        rst;
    logic [11:0] keys;
    logic [9:0]  period_o0;
    logic [9:0]  period_o2;

    int checks   = 0;
    int failures = 0;

    localparam int TBL [12] = '{382, 361, 341, 321, 303, 286, 270, 255, 241, 227, 215, 202};

    wave_period_calculator #(.OCTAVE(0)) dut (
        .clk(clk), .rst(rst),
        .key1(keys[0]), .key2(keys[1]), .key3(keys[2]), .key4(keys[3]),
        .key5(keys[4]), .key6(keys[5]), .key7(keys[6]), .key8(keys[7]),
        .key9(keys[8]), .key10(keys[9]), .key11(keys[10]), .key12(keys[11]),
        .halfPeriodTotal(period_o0)
    );

    wave_period_calculator #(.OCTAVE(2)) dut_oct2 (
        .clk(clk), .rst(rst),
        .key1(keys[0]), .key2(keys[1]), .key3(keys[2]), .key4(keys[3]),
        .key5(keys[4]), .key6(keys[5]), .key7(keys[6]), .key8(keys[7]),
        .key9(keys[8]), .key10(keys[9]), .key11(keys[10]), .key12(keys[11]),
        .halfPeriodTotal(period_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = '0;

        // reset with no keys
        step();
        chk("rst_during", period_o0, 10'd0);
        chk("rst_during_oct2", period_o2, 10'd0);
        rst = 1'b0;
        step();
        chk("rst_after", period_o0, 10'd0);
        step();
        chk("rst_after2", period_o0, 10'd0);

        // key1 single press: 0 for two edges, 382 from the third
        keys = 12'b0000_0000_0001;
        step();
        chk("k1_edge1", period_o0, 10'd0);
        step();
        chk("k1_edge2", period_o0, 10'd0);
        step();
        chk("k1_edge3", period_o0, 10'd382);
        chk("k1_oct2", period_o2, 10'd95);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("k1_hold_c%0d", c), period_o0, 10'd382);
        end
        keys = '0;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk($sformatf("k1_release_c%0d", c), period_o0, (c >= 3) ? 10'd0 : 10'd382);
        end

        // full sweep, each key 6 cycles, then 4 idle cycles
        for (int i = 0; i < 12; i++) begin
            keys = 12'd1 << i;
            for (int c = 1; c <= 6; c++) begin
                step();
                chk($sformatf("sweep_k%0d_press_c%0d", i + 1, c), period_o0,
                    (c >= 3) ? 10'(TBL[i]) : 10'd0);
                chk($sformatf("sweep_k%0d_oct2_c%0d", i + 1, c), period_o2,
                    (c >= 3) ? 10'(TBL[i] >> 2) : 10'd0);
            end
            keys = '0;
            for (int c = 1; c <= 4; c++) begin
                step();
                chk($sformatf("sweep_k%0d_rel_c%0d", i + 1, c), period_o0,
                    (c >= 3) ? 10'd0 : 10'(TBL[i]));
            end
        end

        // simultaneous key3 + key10: highest wins
        keys = 12'b0010_0000_0100;
        step();
        step();
        step();
        chk("simul_k3_k10", period_o0, 10'd227);
        step();
        chk("simul_k3_k10_hold", period_o0, 10'd227);
        keys = 12'b0000_0000_0100;
        step();
        chk("simul_rel_edge1", period_o0, 10'd227);
        step();
        chk("simul_rel_edge2", period_o0, 10'd227);
        step();
        chk("simul_rel_edge3", period_o0, 10'd341);

        // all keys: key12 wins
        keys = 12'hFFF;
        step();
        step();
        step();
        chk("all_keys", period_o0, 10'd202);
        chk("all_keys_oct2", period_o2, 10'd50);

        // reset mid-note with key5
        keys = 12'b0000_0001_0000;
        step();
        step();
        step();
        chk("k5_before_rst", period_o0, 10'd303);
        rst = 1'b1;
        step();
        chk("k5_rst_edge1", period_o0, 10'd0);
        step();
        chk("k5_rst_edge2", period_o0, 10'd0);
        rst = 1'b0;
        step();
        chk("k5_post_edge1", period_o0, 10'd0);
        step();
        chk("k5_post_edge2", period_o0, 10'd0);
        step();
        chk("k5_post_edge3", period_o0, 10'd303);
        chk("k5_post_oct2", period_o2, 10'd75);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
